// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode encodings and FSM states.
package alu_pkg;

  // ALU opcode encodings; the controller only passes these through.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MULT = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_NOR  = 3'b111;

  // Issue controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MULT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_mult_cycle_counter.sv
// Counts the cycles of one multiply: cleared on load, advances while enabled,
// flags its final count so the controller knows the product is ready.
module mult_cycle_counter #(
  parameter int MULT_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  // A single-cycle multiplier still needs a one-bit counter.
  localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MULT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tc = (count_q == LAST);

  // Next count: load clears, enable advances and wraps after the last count.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  // Count register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller sitting between a valid/ready request stream and an ALU
// with a sequential multiplier: latches operands, waits one cycle (or the
// multiplier duration), captures the result and holds it until taken.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int         MULT_CYCLES = 32,
  parameter logic [2:0] OP_MULT     = ALU_MULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_rst,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_op,
  output logic        busy
);

  state_t      state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        alu_rst_q, alu_rst_d;
  logic [31:0] out_result_q, out_result_d;
  logic [2:0]  out_op_q, out_op_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic        mult_tc;

  // Ready in IDLE, or in DONE when the held result is being taken this cycle.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  mult_cycle_counter #(
    .MULT_CYCLES (MULT_CYCLES)
  ) u_mult_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (state_q == ST_MULT),
    .tc   (mult_tc)
  );

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_rst_d    = 1'b0;
    out_result_d = out_result_q;
    out_op_d     = out_op_q;

    unique case (state_q)
      ST_EXEC: begin
        state_d      = ST_DONE;
        out_result_d = alu_result;
        out_op_d     = alu_op_q;
      end
      ST_MULT: begin
        if (mult_tc) begin
          state_d      = ST_DONE;
          out_result_d = alu_result;
          out_op_d     = alu_op_q;
        end
      end
      ST_DONE: begin
        if (out_ready && !accept) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new request overrides whatever the current state chose (back-to-back from DONE).
    if (accept) begin
      alu_a_d   = in_a;
      alu_b_d   = in_b;
      alu_op_d  = in_op;
      alu_rst_d = (in_op == OP_MULT);
      state_d   = (in_op == OP_MULT) ? ST_MULT : ST_EXEC;
    end

    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs, cleared asynchronously so a pending op is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_rst_q    <= 1'b0;
      out_result_q <= '0;
      out_op_q     <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_rst_q    <= alu_rst_d;
      out_result_q <= out_result_d;
      out_op_q     <= out_op_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_rst    = alu_rst_q;
  assign out_result = out_result_q;
  assign out_op     = out_op_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001: Parameter MULT_CYCLES, default 32, number of cycles the sequential multiplier needs to produce a valid product after restart.
REQ-002: Parameter OP_MULT, default 3'b010, aluop encoding that selects the multiplier output.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst  input  1  reset, asynchronous, active-low.
REQ-005: in_valid  input  1  upstream request valid.
REQ-006: in_ready  output  1  block can accept a request this cycle.
REQ-007: in_a, in_b  input  32 each  operands.
REQ-008: in_op  input  3  ALU operation code.
REQ-009: alu_a, alu_b  output  32 each  operands driven to the ALU.
REQ-010: alu_op  output  3  opcode driven to the ALU.
REQ-011: alu_rst  output  1  active-high one-cycle multiplier restart pulse to the ALU.
REQ-012: alu_result  input  32  ALU result.
REQ-013: out_valid  output  1  result valid to downstream.
REQ-014: out_ready  input  1  downstream accepts result.
REQ-015: out_result  output  32  registered result.
REQ-016: out_op  output  3  opcode that produced out_result.
REQ-017: busy  output  1  high whenever state is not IDLE.

Function
REQ-018: FSM states SHALL be IDLE, EXEC, MULT, DONE.
REQ-019: in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, else 0 (combinational).
REQ-020: Accept = in_valid & in_ready; on accept, in_a/in_b/in_op SHALL be registered into alu_a/alu_b/alu_op and held stable until the next accept.
REQ-021: Accept with in_op != OP_MULT -> EXEC; in_op == OP_MULT -> MULT.
REQ-022: EXEC lasts exactly one cycle; at its end alu_result SHALL be captured into out_result and state -> DONE.
REQ-023: In the first MULT cycle alu_rst SHALL be 1; it SHALL be 0 in every other cycle.
REQ-024: MULT SHALL count MULT_CYCLES cycles (counter 0..MULT_CYCLES-1); at the end of the last counted cycle alu_result is captured and state -> DONE.
REQ-025: Latency accept-edge to out_valid: 2 cycles for non-mult ops, MULT_CYCLES+1 cycles for mult.
REQ-026: out_valid SHALL be 1 exactly in DONE; out_result/out_op SHALL stay constant while out_valid=1 and out_ready=0.
REQ-027: DONE with out_ready=1 and no accept -> IDLE; with simultaneous accept -> EXEC or MULT directly (back-to-back, no bubble).
REQ-028: in_valid during EXEC/MULT, or in DONE with out_ready=0, SHALL be ignored (no register change).
REQ-029: out_ready in any state other than DONE SHALL have no effect.
REQ-030: Opcodes SHALL pass through unmodified; the block performs no arithmetic.

Reset
REQ-031: rst low SHALL immediately force state IDLE, counter 0, alu_a/alu_b/out_result 0, alu_op/out_op 0, alu_rst 0, out_valid 0, busy 0.
REQ-032: Reset mid-MULT or mid-DONE SHALL discard the pending operation; no result is emitted after rst releases.
REQ-033: First accept is possible in the first cycle after rst deasserts.

Structure
REQ-034: Shared package alu_pkg SHALL hold the opcode constants (ADD, SUB, MULT, XOR, AND, OR, SLT, NOR) and the FSM state encoding.
REQ-035: One sub-module, mult_cycle_counter (load/enable/terminal-count, width clog2(MULT_CYCLES)), is natural; the rest is inline.

Verification
REQ-036: Reset, then ADD a=5 b=7 accepted cycle 0 -> out_valid at cycle 2, out_result=12 (bench ALU model), out_op=000.
REQ-037: MULT a=3 b=4, MULT_CYCLES=32 -> alu_rst=1 only in cycle 1, out_valid at cycle 33, out_result=12, busy=1 cycles 1-32.
REQ-038: out_ready held 0 for 10 cycles in DONE -> out_valid and out_result=12 stable; in_valid asserted meanwhile -> in_ready=0, alu_a unchanged.
REQ-039: DONE with out_ready=1 and in_valid=1 (SUB a=10 b=3) -> accepted same cycle, next out_valid 2 cycles later with out_result=7, no IDLE cycle.
REQ-040: rst low at MULT cycle 15 -> all outputs 0 immediately; after release no out_valid until a new accept.
REQ-041: SLT a=-1 b=1 -> out_result=1; NOR a=0 b=0 -> out_result=32'hFFFFFFFF.
